// File: rtl/mcu_spi_link_pkg.sv
// Shared types for the MCU SPI physical link: FSM state encoding and watchdog width.
package mcu_spi_link_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        STRETCH = 2'd2,
        GAP     = 2'd3
    } link_state_e;

    localparam int WDOG_W = 16;

endpackage

// File: rtl/mcu_spi_link_ready_filter.sv
// mcu_ready_filter: 2-FF synchronizer, low-level deglitch counter and one-cycle falling-edge pulse
// for an asynchronous active-low MCU strobe. Pin-low to pulse latency is 2 + FILTER_LEN cycles.
module mcu_ready_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic fall_pulse
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        sync1_d = strobe_n;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(FILTER_LEN)) begin
            // Saturating count: the pulse fires only on the step into FILTER_LEN.
            cnt_d   = cnt_q + 1'b1;
            pulse_d = (cnt_q == CNT_W'(FILTER_LEN - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign fall_pulse = pulse_q;

endmodule

// File: rtl/mcu_spi_link.sv
// Physical-side MCU SPI stage: ready conditioning, SCK enable, MOSI/CS retime, CS gap and stretch
// watchdog. Define MCU_SPI_LOOPBACK_EN to add LoopbackSel (SPIDi from registered MOSI, pins idle).
module mcu_spi_link
    import mcu_spi_link_pkg::*;
#(
    parameter int FILTER_LEN     = 3,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CS_GAP         = 4
) (
    input  logic SClk,
    input  logic nReset,
    input  logic SPIClkRunning,
    input  logic SPIClkStretch,
    input  logic SPIDo,
    input  logic nMCUSel,
    output logic SPIDi,
    output logic MCUReadyFallingEdge,
    output logic MCUSckEn,
    output logic MCUMosi,
    output logic nMCUCs,
    input  logic MCUMiso,
    input  logic MCUReady,
    output logic CsGapBusy,
    output logic Timeout,
`ifdef MCU_SPI_LOOPBACK_EN
    input  logic LoopbackSel,
`endif
    input  logic TimeoutClr
);

    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    link_state_e       state_q, state_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              sck_en_q, sck_en_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              timeout_q, timeout_d;
    logic              ready_edge;
    logic              wdog_hit;
    logic              pulse;
    logic              tmo_set;
    logic              lb_sel;

`ifdef MCU_SPI_LOOPBACK_EN
    assign lb_sel = LoopbackSel;
`else
    assign lb_sel = 1'b0;
`endif

    mcu_ready_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_ready_filter (
        .clk       (SClk),
        .rst_n     (nReset),
        .strobe_n  (MCUReady),
        .fall_pulse(ready_edge)
    );

    assign wdog_hit = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        wdog_d  = '0;
        gap_d   = '0;
        pulse   = 1'b0;
        tmo_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!nMCUSel) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (nMCUSel)            state_d = GAP;
                else if (SPIClkStretch) state_d = STRETCH;
            end
            STRETCH: begin
                wdog_d = wdog_q + 1'b1;
                if (nMCUSel) begin
                    state_d = GAP;
                end else if (ready_edge || wdog_hit) begin
                    // A genuine ready edge on the timeout cycle wins; no timeout is flagged.
                    state_d = ACTIVE;
                    pulse   = 1'b1;
                    tmo_set = wdog_hit && !ready_edge;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_W'(CS_GAP - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        sck_en_d  = SPIClkRunning && !SPIClkStretch && !nMCUSel && !lb_sel;
        mosi_d    = SPIDo;
        // CS is held high for every cycle the link sits in the gap, even if the engine reselects.
        cs_n_d    = nMCUSel || (state_d == GAP) || lb_sel;
        timeout_d = tmo_set || (timeout_q && !TimeoutClr);
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            wdog_q    <= '0;
            gap_q     <= '0;
            sck_en_q  <= 1'b0;
            mosi_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            gap_q     <= gap_d;
            sck_en_q  <= sck_en_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            timeout_q <= timeout_d;
        end
    end

    assign MCUReadyFallingEdge = pulse;
    assign MCUSckEn            = sck_en_q;
    assign MCUMosi             = mosi_q;
    assign nMCUCs              = cs_n_q;
    assign CsGapBusy           = (state_q == GAP);
    assign Timeout             = timeout_q;
    assign SPIDi               = lb_sel ? mosi_q : MCUMiso;

endmodule

// File: tb/tb_mcu_spi_link.sv
// Self-checking bench for mcu_spi_link: randomized scenarios against a behavioural timing model.
module tb_mcu_spi_link;
    import mcu_spi_link_pkg::*;

    localparam int FILTER_LEN     = 3;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CS_GAP         = 4;
    localparam int READY_LAT      = 2 + FILTER_LEN;

    logic SClk = 1'b0;
    logic nReset, SPIClkRunning, SPIClkStretch, SPIDo, nMCUSel;
    logic SPIDi, MCUReadyFallingEdge, MCUSckEn, MCUMosi, nMCUCs;
    logic MCUMiso, MCUReady, CsGapBusy, Timeout, TimeoutClr;
`ifdef MCU_SPI_LOOPBACK_EN
    logic LoopbackSel = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 SClk = ~SClk;

    mcu_spi_link #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CS_GAP        (CS_GAP)
    ) dut (
        .SClk               (SClk),
        .nReset             (nReset),
        .SPIClkRunning      (SPIClkRunning),
        .SPIClkStretch      (SPIClkStretch),
        .SPIDo              (SPIDo),
        .nMCUSel            (nMCUSel),
        .SPIDi              (SPIDi),
        .MCUReadyFallingEdge(MCUReadyFallingEdge),
        .MCUSckEn           (MCUSckEn),
        .MCUMosi            (MCUMosi),
        .nMCUCs             (nMCUCs),
        .MCUMiso            (MCUMiso),
        .MCUReady           (MCUReady),
        .CsGapBusy          (CsGapBusy),
        .Timeout            (Timeout),
`ifdef MCU_SPI_LOOPBACK_EN
        .LoopbackSel        (LoopbackSel),
`endif
        .TimeoutClr         (TimeoutClr)
    );

    // One cycle: outputs are sampled 1 time unit after the rising edge, inputs change right after.
    task automatic step();
        @(posedge SClk);
        #1;
    endtask

    // From Idle: select, one Active cycle, then request a stretch. Returns in the first Stretch cycle.
    task automatic go_stretch();
        nMCUSel       = 1'b0;
        SPIClkRunning = 1'b1;
        SPIClkStretch = 1'b0;
        step();
        SPIClkStretch = 1'b1;
        step();
    endtask

    task automatic end_txn();
        SPIClkStretch = 1'b0;
        SPIClkRunning = 1'b0;
        nMCUSel       = 1'b1;
        MCUReady      = 1'b1;
        repeat (CS_GAP + 3) step();
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        SPIClkRunning = 1'b1; SPIClkStretch = 1'b0; SPIDo = 1'b0; nMCUSel = 1'b0;
        MCUMiso = 1'b0; MCUReady = 1'b0; TimeoutClr = 1'b0;
        repeat (3) step();
        checks++; if (MCUSckEn !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", MCUSckEn); end
        checks++; if (MCUMosi !== 1'b1) begin errors++; $display("FAIL reset_mosi got %b want 1", MCUMosi); end
        checks++; if (nMCUCs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", nMCUCs); end
        checks++; if (MCUReadyFallingEdge !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", MCUReadyFallingEdge); end
        checks++; if (CsGapBusy !== 1'b0) begin errors++; $display("FAIL reset_gapbusy got %b want 0", CsGapBusy); end
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", Timeout); end
        checks++; if (SPIDi !== MCUMiso) begin errors++; $display("FAIL reset_spidi got %b want %b", SPIDi, MCUMiso); end
        SPIClkRunning = 1'b0; nMCUSel = 1'b1; MCUReady = 1'b1;
        nReset = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_ready_edge();
        for (int r = 0; r < 3; r++) begin
            int hold, first_c, n_pulse;
            hold = $urandom_range(10, FILTER_LEN);
            first_c = -1; n_pulse = 0;
            go_stretch();
            MCUReady = 1'b0;
            for (int c = 1; c <= 14; c++) begin
                step();
                if (c == first_c + 1 && first_c > 0) begin
                    checks++;
                    if (dut.state_q !== ACTIVE) begin errors++; $display("FAIL ready_state got %0d want %0d", dut.state_q, ACTIVE); end
                end
                if (MCUReadyFallingEdge === 1'b1) begin
                    n_pulse++;
                    if (first_c < 0) first_c = c;
                    SPIClkStretch = 1'b0;
                end
                if (c == hold) MCUReady = 1'b1;
            end
            checks++; if (first_c != READY_LAT) begin errors++; $display("FAIL ready_latency got %0d want %0d", first_c, READY_LAT); end
            checks++; if (n_pulse != 1) begin errors++; $display("FAIL ready_count got %0d want 1", n_pulse); end
            end_txn();
        end
    endtask

    task automatic test_glitch();
        int g, first_c;
        g = $urandom_range(FILTER_LEN - 1, 1);
        first_c = -1;
        go_stretch();
        MCUReady = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == g) MCUReady = 1'b1;
            checks++;
            if (MCUReadyFallingEdge !== 1'b0) begin errors++; $display("FAIL glitch_pulse cyc %0d got %b want 0", c, MCUReadyFallingEdge); end
        end
        checks++; if (dut.state_q !== STRETCH) begin errors++; $display("FAIL glitch_state got %0d want %0d", dut.state_q, STRETCH); end
        // A fresh low must need the full latency again, so the count was cleared by the glitch recovery.
        MCUReady = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (MCUReadyFallingEdge === 1'b1 && first_c < 0) begin
                first_c = c;
                SPIClkStretch = 1'b0;
            end
        end
        checks++; if (first_c != READY_LAT) begin errors++; $display("FAIL glitch_relatency got %0d want %0d", first_c, READY_LAT); end
        end_txn();
    endtask

    task automatic test_swallow();
        int n_pulse;
        n_pulse = 0;
        nMCUSel = 1'b0; SPIClkRunning = 1'b1; SPIClkStretch = 1'b0;
        step();
        MCUReady = 1'b0;
        for (int c = 1; c <= READY_LAT + 4; c++) begin
            step();
            if (MCUReadyFallingEdge === 1'b1) n_pulse++;
        end
        checks++; if (n_pulse != 0) begin errors++; $display("FAIL swallow_count got %0d want 0", n_pulse); end
        end_txn();
    endtask

    task automatic test_timeout();
        int k, n_pulse;
        bit seen;
        // Plain timeout: pulse in the TIMEOUT_CYCLES-th stretch cycle.
        go_stretch();
        k = 1; seen = 0;
        while (!seen && k <= 40) begin
            if (MCUReadyFallingEdge === 1'b1) seen = 1;
            else begin step(); k++; end
        end
        checks++; if (k != TIMEOUT_CYCLES) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", k, TIMEOUT_CYCLES); end
        SPIClkStretch = 1'b0;
        step();
        checks++; if (Timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got %b want 1", Timeout); end
        repeat ($urandom_range(3, 0)) step();
        checks++; if (Timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", Timeout); end
        TimeoutClr = 1'b1; step(); TimeoutClr = 1'b0;
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL timeout_clr got %b want 0", Timeout); end

        // Clear on the same cycle as a new timeout: the new timeout wins.
        SPIClkStretch = 1'b1; step();
        k = 1; seen = 0;
        while (!seen && k <= 40) begin
            if (MCUReadyFallingEdge === 1'b1) seen = 1;
            else begin step(); k++; end
        end
        checks++; if (k != TIMEOUT_CYCLES) begin errors++; $display("FAIL timeout2_cycle got %0d want %0d", k, TIMEOUT_CYCLES); end
        SPIClkStretch = 1'b0; TimeoutClr = 1'b1;
        step();
        TimeoutClr = 1'b0;
        checks++; if (Timeout !== 1'b1) begin errors++; $display("FAIL timeout_clr_race got %b want 1", Timeout); end
        TimeoutClr = 1'b1; step(); TimeoutClr = 1'b0;

        // Ready edge landing on the timeout cycle: one pulse, no timeout flag.
        SPIClkStretch = 1'b1; step();
        n_pulse = 0; k = -1;
        for (int c = 1; c <= 20; c++) begin
            if (MCUReadyFallingEdge === 1'b1) begin
                n_pulse++;
                if (k < 0) k = c;
                SPIClkStretch = 1'b0;
                MCUReady = 1'b1;
            end
            if (c == TIMEOUT_CYCLES - READY_LAT) MCUReady = 1'b0;
            step();
        end
        checks++; if (k != TIMEOUT_CYCLES) begin errors++; $display("FAIL race_cycle got %0d want %0d", k, TIMEOUT_CYCLES); end
        checks++; if (n_pulse != 1) begin errors++; $display("FAIL race_count got %0d want 1", n_pulse); end
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL race_timeout got %b want 0", Timeout); end
        end_txn();
    endtask

    task automatic test_cs_gap();
        for (int r = 0; r < 3; r++) begin
            int d, busy_n, cs_hi_n, first_busy;
            d = (r == 0) ? 1 : $urandom_range(3, 1);
            busy_n = 0; cs_hi_n = 0; first_busy = -1;
            nMCUSel = 1'b0; SPIClkRunning = 1'b0; SPIClkStretch = 1'b0;
            step(); step();
            nMCUSel = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                step();
                if (CsGapBusy === 1'b1) begin
                    busy_n++;
                    if (first_busy < 0) first_busy = c;
                end
                if (nMCUCs === 1'b1) cs_hi_n++;
                if (c == d) nMCUSel = 1'b0;
            end
            checks++; if (busy_n != CS_GAP) begin errors++; $display("FAIL gap_busy_len got %0d want %0d", busy_n, CS_GAP); end
            checks++; if (first_busy != 1) begin errors++; $display("FAIL gap_busy_start got %0d want 1", first_busy); end
            checks++; if (cs_hi_n < CS_GAP || cs_hi_n > CS_GAP + 1) begin errors++; $display("FAIL gap_cs_len got %0d want %0d", cs_hi_n, CS_GAP); end
            checks++; if (nMCUCs !== 1'b0) begin errors++; $display("FAIL gap_cs_reselect got %b want 0", nMCUCs); end
            end_txn();
        end
    endtask

    task automatic test_serial();
        for (int r = 0; r < 3; r++) begin
            logic [7:0] byte_v, got;
            int sck_n;
            byte_v = (r == 0) ? 8'hA5 : 8'($urandom);
            got = '0; sck_n = 0;
            nMCUSel = 1'b0; SPIClkRunning = 1'b0; SPIClkStretch = 1'b0;
            step();
            SPIClkRunning = 1'b1;
            for (int i = 7; i >= 0; i--) begin
                SPIDo = byte_v[i];
                step();
                got[i] = MCUMosi;
                if (MCUSckEn === 1'b1) sck_n++;
            end
            SPIClkRunning = 1'b0; SPIDo = 1'b1;
            step();
            checks++; if (got !== byte_v) begin errors++; $display("FAIL serial_mosi got %h want %h", got, byte_v); end
            checks++; if (sck_n != 8) begin errors++; $display("FAIL serial_sck_len got %0d want 8", sck_n); end
            checks++; if (MCUSckEn !== 1'b0) begin errors++; $display("FAIL serial_sck_stop got %b want 0", MCUSckEn); end
            end_txn();
        end
    endtask

    task automatic test_random_datapath();
        logic exp_mosi, exp_sck;
        for (int c = 0; c < 40; c++) begin
            SPIDo = 1'($urandom); SPIClkRunning = 1'($urandom); SPIClkStretch = 1'($urandom);
            nMCUSel = ($urandom_range(7, 0) == 0); MCUMiso = 1'($urandom);
            exp_mosi = SPIDo;
            exp_sck = SPIClkRunning & ~SPIClkStretch & ~nMCUSel;
            step();
            checks++; if (MCUMosi !== exp_mosi) begin errors++; $display("FAIL rnd_mosi cyc %0d got %b want %b", c, MCUMosi, exp_mosi); end
            checks++; if (MCUSckEn !== exp_sck) begin errors++; $display("FAIL rnd_sck cyc %0d got %b want %b", c, MCUSckEn, exp_sck); end
            checks++; if (SPIDi !== MCUMiso) begin errors++; $display("FAIL rnd_spidi cyc %0d got %b want %b", c, SPIDi, MCUMiso); end
        end
        end_txn();
        TimeoutClr = 1'b1; step(); TimeoutClr = 1'b0;
    endtask

    task automatic test_reset_mid_stretch();
        nMCUSel = 1'b0; SPIClkRunning = 1'b1; SPIClkStretch = 1'b0; SPIDo = 1'b0;
        step();
        SPIClkStretch = 1'b1;
        // Stretch is left asserted so the link re-enters Stretch right after the timeout.
        repeat (TIMEOUT_CYCLES + 4) step();
        checks++; if (Timeout !== 1'b1) begin errors++; $display("FAIL mid_pre_timeout got %b want 1", Timeout); end
        checks++; if (nMCUCs !== 1'b0 || MCUMosi !== 1'b0) begin errors++; $display("FAIL mid_pre_pins got cs %b mosi %b want 0 0", nMCUCs, MCUMosi); end
        #2 nReset = 1'b0;
        #1;
        checks++; if (MCUMosi !== 1'b1) begin errors++; $display("FAIL mid_mosi got %b want 1", MCUMosi); end
        checks++; if (nMCUCs !== 1'b1) begin errors++; $display("FAIL mid_cs got %b want 1", nMCUCs); end
        checks++; if (MCUSckEn !== 1'b0) begin errors++; $display("FAIL mid_sck got %b want 0", MCUSckEn); end
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL mid_timeout got %b want 0", Timeout); end
        checks++; if (MCUReadyFallingEdge !== 1'b0 || CsGapBusy !== 1'b0) begin errors++; $display("FAIL mid_pulse_busy got %b %b want 0 0", MCUReadyFallingEdge, CsGapBusy); end
        SPIClkStretch = 1'b0; SPIClkRunning = 1'b0; nMCUSel = 1'b1;
        step();
        nReset = 1'b1;
        step();
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL mid_release_state got %0d want %0d", dut.state_q, IDLE); end
    endtask

    initial begin
        test_reset();
        test_ready_edge();
        test_glitch();
        test_swallow();
        test_timeout();
        test_cs_gap();
        test_serial();
        test_random_datapath();
        test_reset_mid_stretch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
